// File: rtl/he_lb_err_inj_pkg.sv
// Shared types and helpers for the HE-LB protocol-checker error injection sequencer.
package he_lb_err_inj_pkg;

   typedef enum logic [3:0] {
      ERR_NONE                        = 4'd0,
      ERR_TX_VALID_VIOLATION          = 4'd1,
      ERR_TX_MWR_INSUFFICIENT_DATA    = 4'd2,
      ERR_TX_MWR_DATA_PAYLOAD_OVERRUN = 4'd3,
      ERR_MMIO_INSUFFICIENT_DATA      = 4'd4,
      ERR_MMIO_DATA_PAYLOAD_OVERRUN   = 4'd5,
      ERR_MMIO_TIMEOUT                = 4'd6,
      ERR_UNEXP_MMIO_RSP              = 4'd7,
      ERR_TAG_OCCUPIED                = 4'd8,
      ERR_MAX_TAG                     = 4'd9,
      ERR_MAX_READ_REQ_SIZE           = 4'd10,
      ERR_MAX_PAYLOAD                 = 4'd11,
      ERR_MALFORMED_TLP               = 4'd12
   } t_err_code;

   // Field order puts code N on bit N-1.
   typedef struct packed {
      logic malformed_tlp;
      logic max_payload;
      logic max_read_req_size;
      logic max_tag;
      logic tag_occupied;
      logic unexp_mmio_rsp;
      logic mmio_timeout;
      logic mmio_data_payload_overrun;
      logic mmio_insufficient_data;
      logic tx_mwr_data_payload_overrun;
      logic tx_mwr_insufficient_data;
      logic tx_valid_violation;
   } t_prtcl_chkr_err_vector;

   typedef enum logic [2:0] {
      CLS_NONE = 3'd0,
      CLS_MWR  = 3'd1,
      CLS_MRD  = 3'd2,
      CLS_MEM  = 3'd3,
      CLS_CPL  = 3'd4,
      CLS_ANY  = 3'd5
   } t_tlp_class;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ARMED  = 2'd1,
      ST_ACTIVE = 2'd2,
      ST_DRAIN  = 2'd3
   } t_ctrl_state;

   function automatic logic func_code_valid(input logic [3:0] code);
      return (code >= 4'd1) && (code <= 4'd12);
   endfunction

   function automatic t_prtcl_chkr_err_vector func_code_to_vec(input logic [3:0] code);
      logic [11:0] vec;
      vec = 12'd0;
      if (func_code_valid(code)) begin
         vec = 12'd1 << (code - 4'd1);
      end else begin
         vec = 12'd0;
      end
      return t_prtcl_chkr_err_vector'(vec);
   endfunction

   function automatic t_tlp_class func_code_class(input logic [3:0] code);
      case (code)
         4'd1:                      return CLS_MEM;
         4'd2, 4'd3, 4'd11:         return CLS_MWR;
         4'd4, 4'd5, 4'd6, 4'd7:    return CLS_CPL;
         4'd8, 4'd9, 4'd10:         return CLS_MRD;
         4'd12:                     return CLS_ANY;
         default:                   return CLS_NONE;
      endcase
   endfunction

   function automatic logic func_class_match(input t_tlp_class cls, input logic mwr,
                                             input logic mrd, input logic cpl);
      case (cls)
         CLS_MWR: return mwr;
         CLS_MRD: return mrd;
         CLS_MEM: return mwr | mrd;
         CLS_CPL: return cpl;
         CLS_ANY: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/he_lb_err_inj_ctrl_if.sv
// Command, TX-stream tap and status bundle of the error injection sequencer.
interface he_lb_err_inj_ctrl_if
   import he_lb_err_inj_pkg::*;
#(
   parameter int CNT_W = 8
);
   logic                   ctrl_arm;
   logic [3:0]             ctrl_code;
   logic [CNT_W-1:0]       ctrl_count;
   logic                   ctrl_abort;
   logic                   tx_tvalid;
   logic                   tx_tready;
   logic                   tx_tlast;
   logic                   tx_hdr_mwr;
   logic                   tx_hdr_mrd;
   logic                   tx_hdr_cpl;
   t_prtcl_chkr_err_vector error_inj;
   logic                   sts_busy;
   logic                   sts_done;
   logic                   sts_timeout;
   logic                   sts_cfg_err;
   logic [CNT_W-1:0]       sts_inj_cnt;

   modport master (
      output ctrl_arm, ctrl_code, ctrl_count, ctrl_abort,
      output tx_tvalid, tx_tready, tx_tlast, tx_hdr_mwr, tx_hdr_mrd, tx_hdr_cpl,
      input  error_inj, sts_busy, sts_done, sts_timeout, sts_cfg_err, sts_inj_cnt
   );

   modport slave (
      input  ctrl_arm, ctrl_code, ctrl_count, ctrl_abort,
      input  tx_tvalid, tx_tready, tx_tlast, tx_hdr_mwr, tx_hdr_mrd, tx_hdr_cpl,
      output error_inj, sts_busy, sts_done, sts_timeout, sts_cfg_err, sts_inj_cnt
   );
endinterface

// File: rtl/he_lb_pkt_trk.sv
// TX stream packet tracker: packet boundaries and completion of packets of a chosen class.
module he_lb_pkt_trk
   import he_lb_err_inj_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tvalid_i,
   input  logic       tready_i,
   input  logic       tlast_i,
   input  logic       hdr_mwr_i,
   input  logic       hdr_mrd_i,
   input  logic       hdr_cpl_i,
   input  t_tlp_class qual_class_i,
   output logic       bnd_o,
   output logic       pkt_end_o,
   output logic       qual_cmpl_o
);
   logic in_pkt_q;
   logic cur_qual_q;
   logic hs_s;
   logic sop_s;
   logic sop_qual_s;

   // Beat decode; header class only matters on the SOP beat.
   always_comb begin
      hs_s       = tvalid_i & tready_i;
      sop_s      = tvalid_i & ~in_pkt_q;
      sop_qual_s = func_class_match(qual_class_i, hdr_mwr_i, hdr_mrd_i, hdr_cpl_i);
      bnd_o      = (~in_pkt_q & ~tvalid_i) | (hs_s & tlast_i);
      pkt_end_o  = hs_s & tlast_i;
      if (sop_s) begin
         qual_cmpl_o = hs_s & tlast_i & sop_qual_s;
      end else begin
         qual_cmpl_o = hs_s & tlast_i & cur_qual_q;
      end
   end

   // In-packet flag and class latched at the SOP handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_pkt_q   <= 1'b0;
         cur_qual_q <= 1'b0;
      end else begin
         if (hs_s) begin
            in_pkt_q <= ~tlast_i;
         end
         if (hs_s && sop_s) begin
            cur_qual_q <= sop_qual_s;
         end
      end
   end
endmodule

// File: rtl/he_lb_err_inj_ctrl.sv
// Error injection sequencer: arms on command, raises error_inj on a TLP boundary and
// drops it on a boundary once the requested number of qualifying TLPs has passed.
module he_lb_err_inj_ctrl
   import he_lb_err_inj_pkg::*;
#(
   parameter int CNT_W          = 8,
   parameter int TIMEOUT_CYCLES = 1_000_000
) (
   input  logic                clk,
   input  logic                rst_n,
   he_lb_err_inj_ctrl_if.slave bus
);
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

   t_ctrl_state            state_q;
   t_err_code              code_q;
   logic [CNT_W-1:0]       count_q;
   logic [CNT_W-1:0]       inj_cnt_q;
   logic [WD_W-1:0]        wd_q;
   t_prtcl_chkr_err_vector error_inj_q;
   logic                   busy_q;
   logic                   done_q;
   logic                   timeout_q;
   logic                   cfg_err_q;

   logic                   bnd_s;
   logic                   pkt_end_s;
   logic                   qual_cmpl_s;
   logic                   arm_ok_s;
   logic                   wd_exp_s;
   logic                   exp_act_s;
   logic                   final_s;
   logic [CNT_W-1:0]       inj_cnt_inc_s;
   logic [WD_W-1:0]        wd_inc_s;

   he_lb_pkt_trk u_pkt_trk (
      .clk          (clk),
      .rst_n        (rst_n),
      .tvalid_i     (bus.tx_tvalid),
      .tready_i     (bus.tx_tready),
      .tlast_i      (bus.tx_tlast),
      .hdr_mwr_i    (bus.tx_hdr_mwr),
      .hdr_mrd_i    (bus.tx_hdr_mrd),
      .hdr_cpl_i    (bus.tx_hdr_cpl),
      .qual_class_i (func_code_class(code_q)),
      .bnd_o        (bnd_s),
      .pkt_end_o    (pkt_end_s),
      .qual_cmpl_o  (qual_cmpl_s)
   );

   // Command decode, saturating counters and terminal-condition detection.
   always_comb begin
      arm_ok_s = func_code_valid(bus.ctrl_code) && (bus.ctrl_count != '0);
      wd_exp_s = (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
      wd_inc_s = wd_q + WD_W'(1);
      if (inj_cnt_q == '1) begin
         inj_cnt_inc_s = inj_cnt_q;
      end else begin
         inj_cnt_inc_s = inj_cnt_q + CNT_W'(1);
      end
      final_s   = qual_cmpl_s && (inj_cnt_inc_s == count_q);
      exp_act_s = wd_exp_s && !qual_cmpl_s;
   end

   // Sequencer FSM with registered injection vector and sticky status.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         code_q      <= ERR_NONE;
         count_q     <= '0;
         inj_cnt_q   <= '0;
         wd_q        <= '0;
         error_inj_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         timeout_q   <= 1'b0;
         cfg_err_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               wd_q <= '0;
               if (bus.ctrl_arm && arm_ok_s) begin
                  code_q    <= t_err_code'(bus.ctrl_code);
                  count_q   <= bus.ctrl_count;
                  inj_cnt_q <= '0;
                  done_q    <= 1'b0;
                  timeout_q <= 1'b0;
                  cfg_err_q <= 1'b0;
                  busy_q    <= 1'b1;
                  state_q   <= ST_ARMED;
               end else if (bus.ctrl_arm) begin
                  cfg_err_q <= 1'b1;
               end
            end
            ST_ARMED: begin
               wd_q <= wd_inc_s;
               if (wd_exp_s) begin
                  timeout_q <= 1'b1;
                  busy_q    <= 1'b0;
                  state_q   <= ST_IDLE;
               end else if (bus.ctrl_abort) begin
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end else if (bnd_s) begin
                  error_inj_q <= func_code_to_vec(code_q);
                  state_q     <= ST_ACTIVE;
               end
            end
            ST_ACTIVE: begin
               if (qual_cmpl_s) begin
                  inj_cnt_q <= inj_cnt_inc_s;
                  wd_q      <= '0;
               end else begin
                  wd_q <= wd_inc_s;
               end
               // The final completion outranks abort and expiry in the same cycle.
               if (final_s) begin
                  done_q      <= 1'b1;
                  busy_q      <= 1'b0;
                  error_inj_q <= '0;
                  state_q     <= ST_IDLE;
               end else if (bus.ctrl_abort || exp_act_s) begin
                  busy_q <= 1'b0;
                  if (exp_act_s) begin
                     timeout_q <= 1'b1;
                  end
                  if (bnd_s) begin
                     error_inj_q <= '0;
                     state_q     <= ST_IDLE;
                  end else begin
                     state_q <= ST_DRAIN;
                  end
               end
            end
            ST_DRAIN: begin
               if (pkt_end_s) begin
                  error_inj_q <= '0;
                  state_q     <= ST_IDLE;
               end
            end
            default: begin
               error_inj_q <= '0;
               busy_q      <= 1'b0;
               state_q     <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.error_inj   = error_inj_q;
   assign bus.sts_busy    = busy_q;
   assign bus.sts_done    = done_q;
   assign bus.sts_timeout = timeout_q;
   assign bus.sts_cfg_err = cfg_err_q;
   assign bus.sts_inj_cnt = inj_cnt_q;
endmodule

// File: tb/tb_he_lb_err_inj_ctrl.sv
// Directed bench: each expected output change (value and clock cycle) is queued by the
// stimulus; a negedge monitor pops and compares whenever the DUT outputs change.
module tb_he_lb_err_inj_ctrl;
   logic clk;
   logic rst_n;
   int   cyc;
   int   checks;
   int   errors;
   int   k;

   typedef struct {
      logic [23:0] val;
      int          at;
   } exp_t;

   exp_t  exp_q[$];
   string name_q[$];

   he_lb_err_inj_ctrl_if #(.CNT_W(8)) bus ();

   he_lb_err_inj_ctrl #(.CNT_W(8), .TIMEOUT_CYCLES(100)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Expected output snapshot: {error_inj, busy, done, timeout, cfg_err, inj_cnt}.
   function automatic logic [23:0] mk(input int code, input bit busy, input bit done,
                                      input bit to, input bit cfg, input int cnt);
      logic [11:0] vec;
      vec = 12'd0;
      if (code >= 1 && code <= 12) vec = 12'd1 << (code - 1);
      return {vec, busy, done, to, cfg, 8'(cnt)};
   endfunction

   task automatic expect_at(input string nm, input logic [23:0] v, input int at);
      exp_t e;
      e.val = v;
      e.at  = at;
      exp_q.push_back(e);
      name_q.push_back(nm);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_tx();
      bus.tx_tvalid  = 1'b0;
      bus.tx_tlast   = 1'b0;
      bus.tx_hdr_mwr = 1'b0;
      bus.tx_hdr_mrd = 1'b0;
      bus.tx_hdr_cpl = 1'b0;
      bus.tx_tready  = 1'b1;
   endtask

   task automatic beat(input bit last, input bit mwr, input bit mrd, input bit cpl);
      bus.tx_tvalid  = 1'b1;
      bus.tx_tlast   = last;
      bus.tx_hdr_mwr = mwr;
      bus.tx_hdr_mrd = mrd;
      bus.tx_hdr_cpl = cpl;
   endtask

   task automatic send_pkt(input bit mwr, input bit mrd, input bit cpl, input int n);
      for (int i = 0; i < n; i++) begin
         if (i == 0) beat(n == 1, mwr, mrd, cpl);
         else        beat(i == n - 1, 1'b0, 1'b0, 1'b0);
         tick();
      end
      idle_tx();
   endtask

   task automatic arm(input int code, input int count);
      bus.ctrl_arm   = 1'b1;
      bus.ctrl_code  = 4'(code);
      bus.ctrl_count = 8'(count);
   endtask

   // Monitor: every change of the output bundle consumes one queued expectation.
   initial begin
      logic [23:0] prev;
      logic [23:0] cur;
      exp_t        e;
      string       nm;
      prev = 24'hFFFFFF;
      forever begin
         @(negedge clk);
         cur = {bus.error_inj, bus.sts_busy, bus.sts_done, bus.sts_timeout,
                bus.sts_cfg_err, bus.sts_inj_cnt};
         if (cur !== prev) begin
            prev   = cur;
            checks = checks + 1;
            if (exp_q.size() == 0) begin
               errors = errors + 1;
               $display("FAIL unexpected_change: got %h at cyc %0d, expected no change", cur, cyc);
            end else begin
               e  = exp_q.pop_front();
               nm = name_q.pop_front();
               if (cur !== e.val || (e.at >= 0 && cyc != e.at)) begin
                  errors = errors + 1;
                  $display("FAIL %s: got %h at cyc %0d, expected %h at cyc %0d",
                           nm, cur, cyc, e.val, e.at);
               end
            end
         end
      end
   end

   initial begin
      cyc = 0; checks = 0; errors = 0;
      rst_n = 1'b0;
      bus.ctrl_arm = 1'b0; bus.ctrl_code = 4'd0; bus.ctrl_count = 8'd0; bus.ctrl_abort = 1'b0;
      idle_tx();
      expect_at("reset", mk(0, 0, 0, 0, 0, 0), -1);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (2) tick();

      // Basic count: arm while a 2-beat MWr is in flight, then 4 back-to-back MWr.
      k = cyc;
      expect_at("basic_busy", mk(0, 1, 0, 0, 0, 0), k + 1);
      expect_at("basic_inj",  mk(2, 1, 0, 0, 0, 0), k + 2);
      expect_at("basic_cnt1", mk(2, 1, 0, 0, 0, 1), k + 4);
      expect_at("basic_cnt2", mk(2, 1, 0, 0, 0, 2), k + 6);
      expect_at("basic_done", mk(0, 0, 1, 0, 0, 3), k + 8);
      arm(2, 3); beat(1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      bus.ctrl_arm = 1'b0; beat(1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      repeat (4) send_pkt(1'b1, 1'b0, 1'b0, 2);
      repeat (3) tick();

      // Class filtering: code 8 qualifies MRd only.
      k = cyc;
      expect_at("class_busy", mk(0, 1, 0, 0, 0, 0), k + 1);
      expect_at("class_inj",  mk(8, 1, 0, 0, 0, 0), k + 2);
      expect_at("class_done", mk(0, 0, 1, 0, 0, 1), k + 8);
      arm(8, 1);
      tick();
      bus.ctrl_arm = 1'b0;
      tick();
      send_pkt(1'b0, 1'b0, 1'b1, 2);
      send_pkt(1'b1, 1'b0, 1'b0, 2);
      send_pkt(1'b0, 1'b1, 1'b0, 2);
      repeat (3) tick();

      // Stall stability: SOP beat held with tready low for 5 cycles while ARMED.
      k = cyc;
      expect_at("stall_busy", mk(0, 1, 0, 0, 0, 0), k + 1);
      expect_at("stall_inj",  mk(3, 1, 0, 0, 0, 0), k + 8);
      expect_at("stall_done", mk(0, 0, 1, 0, 0, 1), k + 10);
      arm(3, 1);
      tick();
      bus.ctrl_arm = 1'b0; bus.tx_tready = 1'b0; beat(1'b0, 1'b1, 1'b0, 1'b0);
      repeat (5) tick();
      bus.tx_tready = 1'b1;
      tick();
      beat(1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      send_pkt(1'b1, 1'b0, 1'b0, 2);
      repeat (3) tick();

      // Abort on beat 2 of a 4-beat MWr: drain to the end of the packet.
      k = cyc;
      expect_at("abort_busy",  mk(0, 1, 0, 0, 0, 0), k + 1);
      expect_at("abort_inj",   mk(2, 1, 0, 0, 0, 0), k + 2);
      expect_at("abort_drain", mk(2, 0, 0, 0, 0, 0), k + 4);
      expect_at("abort_clear", mk(0, 0, 0, 0, 0, 0), k + 6);
      arm(2, 5);
      tick();
      bus.ctrl_arm = 1'b0;
      tick();
      beat(1'b0, 1'b1, 1'b0, 1'b0); tick();
      beat(1'b0, 1'b0, 1'b0, 1'b0); bus.ctrl_abort = 1'b1; tick();
      bus.ctrl_abort = 1'b0; tick();
      beat(1'b1, 1'b0, 1'b0, 1'b0); tick();
      idle_tx();
      repeat (3) tick();

      // Watchdog: code 4 with only MWr traffic expires 100 cycles after busy rises.
      k = cyc;
      expect_at("wd_busy",    mk(0, 1, 0, 0, 0, 0), k + 1);
      expect_at("wd_inj",     mk(4, 1, 0, 0, 0, 0), k + 2);
      expect_at("wd_timeout", mk(0, 0, 0, 1, 0, 0), k + 101);
      arm(4, 2);
      tick();
      bus.ctrl_arm = 1'b0;
      tick();
      repeat (3) send_pkt(1'b1, 1'b0, 1'b0, 2);
      repeat (100) tick();

      // Invalid arms: code 0 flags cfg_err; zero count and code 13 must not start.
      k = cyc;
      expect_at("cfg_err", mk(0, 0, 0, 1, 1, 0), k + 1);
      arm(0, 1);  tick();
      arm(5, 0);  tick();
      arm(13, 1); tick();
      bus.ctrl_arm = 1'b0;
      repeat (3) tick();

      // Arm while ACTIVE is ignored; single-beat Cpl counts for code 12; async reset.
      k = cyc;
      expect_at("busyarm_busy", mk(0, 1, 0, 0, 0, 0), k + 1);
      expect_at("busyarm_inj",  mk(12, 1, 0, 0, 0, 0), k + 2);
      expect_at("busyarm_cnt",  mk(12, 1, 0, 0, 0, 1), k + 3);
      expect_at("async_reset",  mk(0, 0, 0, 0, 0, 0), k + 4);
      arm(12, 3);
      tick();
      bus.ctrl_arm = 1'b0;
      tick();
      arm(1, 1); beat(1'b1, 1'b0, 1'b0, 1'b1);
      tick();
      bus.ctrl_arm = 1'b0; idle_tx();
      tick();
      rst_n = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (2) tick();

      // Abort coinciding with the final completion: completion wins.
      k = cyc;
      expect_at("race_busy", mk(0, 1, 0, 0, 0, 0), k + 1);
      expect_at("race_inj",  mk(9, 1, 0, 0, 0, 0), k + 2);
      expect_at("race_cnt1", mk(9, 1, 0, 0, 0, 1), k + 3);
      expect_at("race_done", mk(0, 0, 1, 0, 0, 2), k + 4);
      arm(9, 2);
      tick();
      bus.ctrl_arm = 1'b0;
      tick();
      beat(1'b1, 1'b0, 1'b1, 1'b0); tick();
      beat(1'b1, 1'b0, 1'b1, 1'b0); bus.ctrl_abort = 1'b1; tick();
      idle_tx();
      tick();
      bus.ctrl_abort = 1'b0;
      repeat (5) tick();

      while (exp_q.size() != 0) begin
         checks = checks + 1;
         errors = errors + 1;
         $display("FAIL %s: got no change, expected %h at cyc %0d",
                  name_q[0], exp_q[0].val, exp_q[0].at);
         void'(exp_q.pop_front());
         void'(name_q.pop_front());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/he_lb_err_inj_ctrl.md
# he_lb_err_inj_ctrl

Sequencer for HE-LB protocol-checker error injection. It takes a CSR-style arm command (error code plus TLP count) and drives the one-hot `error_inj` vector into the TX error injector. The vector is raised and dropped only on TLP boundaries of the AFU TX stream, and stays up until the requested number of qualifying TLPs has passed. A watchdog, an abort path and sticky status give software a clean one-shot test flow.

## Interface
- `CNT_W`, default 8: width of the TLP count and injected-count fields.
- `TIMEOUT_CYCLES`, default 1_000_000: watchdog limit in clk cycles without a qualifying TLP completion.
- `clk`  in  1  sole clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ctrl_arm`  in  1  single-cycle arm pulse; samples `ctrl_code`/`ctrl_count`.
- `ctrl_code`  in  4  error code, `t_err_code`: 1..12; 0 and 13..15 are invalid.
- `ctrl_count`  in  CNT_W  number of qualifying TLPs to corrupt; 0 is invalid.
- `ctrl_abort`  in  1  single-cycle abort pulse.
- `tx_tvalid`, `tx_tready`, `tx_tlast`  in  1 each  tap of the TX stream on the injector input side (pre-injection valid, downstream ready).
- `tx_hdr_mwr`, `tx_hdr_mrd`, `tx_hdr_cpl`  in  1 each  header class of the current beat; meaningful on the SOP beat only.
- `error_inj`  out  `t_prtcl_chkr_err_vector`  registered, at most one bit set.
- `sts_busy`  out  1  high in ARMED or ACTIVE.
- `sts_done`  out  1  sticky; requested count completed.
- `sts_timeout`  out  1  sticky; watchdog expired.
- `sts_cfg_err`  out  1  sticky; arm attempted with an invalid code or a zero count.
- `sts_inj_cnt`  out  CNT_W  qualifying TLPs corrupted since the last accepted arm.

## Operation
- **Packet tracking**
  - `hs = tx_tvalid & tx_tready`.
  - `in_pkt` is set on `hs & !tlast` and cleared on `hs & tlast`.
  - SOP beat: `tx_tvalid & !in_pkt`.
  - `bnd` (boundary) = `(!in_pkt & !tx_tvalid) | (hs & tlast)`.
- **Code to field and class**

  | Code | `error_inj` field | Qualifying class |
  |---|---|---|
  | 1 | `tx_valid_violation` | mwr or mrd |
  | 2 | `tx_mwr_insufficient_data` | mwr |
  | 3 | `tx_mwr_data_payload_overrun` | mwr |
  | 4 | `mmio_insufficient_data` | cpl |
  | 5 | `mmio_data_payload_overrun` | cpl |
  | 6 | `mmio_timeout` | cpl |
  | 7 | `unexp_mmio_rsp` | cpl |
  | 8 | `tag_occupied` | mrd |
  | 9 | `max_tag` | mrd |
  | 10 | `max_read_req_size` | mrd |
  | 11 | `max_payload` | mwr |
  | 12 | `malformed_tlp` | any |

- **Qualification:** the class is latched on the SOP handshake into `cur_qual`. A qualifying completion is the `hs & tlast` of a packet with `cur_qual` set; for single-beat packets the SOP class is used directly.
- **FSM states:** IDLE, ARMED, ACTIVE, DRAIN.
- **IDLE**
  - On a valid arm: latch code and count, clear `sts_done`, `sts_timeout`, `sts_cfg_err` and `sts_inj_cnt`, then go to ARMED.
  - On an invalid arm: set `sts_cfg_err` and stay in IDLE.
- **ARMED:** on `bnd`, go to ACTIVE; `error_inj` shows the selected bit from the next cycle.
- **ACTIVE**
  - Each qualifying completion increments `sts_inj_cnt`.
  - When the increment reaches the count: go to IDLE, set `sts_done`, and clear `error_inj` on the next edge.
  - On abort or watchdog expiry: go to IDLE if `bnd` is true this cycle, otherwise go to DRAIN. Expiry also sets `sts_timeout`.
- **DRAIN:** `error_inj` stays asserted until `hs & tlast`, then go to IDLE and clear `error_inj`. A packet is never corrupted on only some of its beats.
- **Watchdog:** counts in ARMED and ACTIVE; resets on arm and on each qualifying completion; expires at `TIMEOUT_CYCLES`.
- **Ignored commands:** arm while busy is ignored with no status change; abort in IDLE is a no-op.
- **Simultaneous events**
  - Abort together with the final completion: the completion wins and `sts_done` is set.
  - Expiry together with the final completion: the completion wins.
  - Arm together with abort in IDLE: the arm wins.

## Timing
- **Reset values:** `error_inj`=0, all status outputs 0, FSM in IDLE, `in_pkt`=0, counters 0. Reset mid-operation returns to IDLE immediately; there is no drain.
- **Output registration:** all outputs are registered; no combinational path from inputs to outputs.
- **Arm to ARMED:** `sts_busy` rises one cycle after `ctrl_arm`.
- **ARMED to ACTIVE:** `error_inj` rises one cycle after the `bnd` cycle. This is never while a beat is held with `tvalid & !tready`, which keeps AXI data stable.
- **Final tlast to IDLE:** on the final qualifying tlast handshake (cycle N), `error_inj` = 0, `sts_busy` = 0 and `sts_done` = 1 in cycle N+1.
- **`sts_inj_cnt`:** saturates at 2^CNT_W−1.

## Structure
- **Package `he_lb_err_inj_pkg`:**
  - `t_err_code` enum.
  - `t_tlp_class` (mwr/mrd/cpl/any).
  - `func_code_to_vec()` returning `t_prtcl_chkr_err_vector`.
  - `func_code_class()`.
  - `func_code_valid()`.
- **Sub-module `he_lb_pkt_trk`:** `in_pkt`, SOP, `bnd` and `cur_qual` tracking, reusable for other TX monitors.
- **Top level:** FSM, counters and status.

## Test plan
- **Basic count:** arm code 2, count 3, with back-to-back 2-beat MWr -> `error_inj.tx_mwr_insufficient_data` rises after the first tlast boundary, covers exactly 3 MWr, `sts_inj_cnt`=3, `sts_done`=1.
- **Class filtering:** arm code 8, count 1, traffic Cpl, MWr, MRd -> Cpl and MWr are not counted; `sts_inj_cnt`=1 after the MRd tlast.
- **Stall stability:** stall `tready` low for 5 cycles on a SOP beat while ARMED -> `error_inj` stays 0 until after that packet's tlast.
- **Abort mid-packet:** abort during beat 2 of a 4-beat MWr -> DRAIN; `error_inj` clears after beat 4; `sts_done`=0.
- **Watchdog:** `TIMEOUT_CYCLES`=100, arm code 4, no Cpl traffic -> `sts_timeout`=1 at cycle 100, `sts_busy`=0.
- **Invalid arm, busy arm and reset:**
  - Arm code 0 -> `sts_cfg_err`=1.
  - Arm while ACTIVE -> ignored.
  - `rst_n` low mid-ACTIVE -> all outputs 0 asynchronously.
